// File: rtl/n64a_vinfo_ctrl_pkg.sv
// Shared constants and types for the video-info controller.
//   Defaults for colour width, PAL threshold and deblur hysteresis,
//   sync-nibble bit positions, the demux slot type and the slot sequencer.
package n64a_vinfo_ctrl_pkg;

  localparam int unsigned COLOR_WIDTH_I     = 7;
  localparam int unsigned PAL_LINE_THRESH   = 288;
  localparam int unsigned DEBLUR_ON_FRAMES  = 4;
  localparam int unsigned DEBLUR_OFF_FRAMES = 2;
  localparam int unsigned LINE_CNT_W        = 9;

  // Positions inside the VD[3:0] sync nibble {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  localparam int unsigned NVSYNC_BIT = 3;
  localparam int unsigned NHSYNC_BIT = 1;

  localparam logic [1:0] DEBLUR_AUTO     = 2'b00;
  localparam logic [1:0] DEBLUR_FORCE_ON = 2'b01;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_R    = 2'd1,
    SLOT_G    = 2'd2,
    SLOT_B    = 2'd3
  } slot_e;

  function automatic slot_e next_slot(input logic sync_cyc, input slot_e cur);
    if (sync_cyc) return SLOT_R;
    case (cur)
      SLOT_R:  return SLOT_G;
      SLOT_G:  return SLOT_B;
      default: return SLOT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/n64a_deblur_detect.sv
// Deblur auto-detector.
//   Watches R/G/B data slots, compares every odd pixel of a line with the
//   preceding even pixel and keeps frame-level hysteresis counters.
//   Ports: clock/reset, data-cycle strobe and slot, colour bus, active-region
//   flag, line-start and frame-end strobes; verdict (registered) and its
//   next-state value for same-edge use by the output packer.
module n64a_deblur_detect
  import n64a_vinfo_ctrl_pkg::*;
#(
  parameter int unsigned color_width_i     = COLOR_WIDTH_I,
  parameter int unsigned deblur_on_frames  = DEBLUR_ON_FRAMES,
  parameter int unsigned deblur_off_frames = DEBLUR_OFF_FRAMES
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     data_cyc_i,
  input  slot_e                    data_cnt_i,
  input  logic [color_width_i-1:0] vd_i,
  input  logic                     active_i,
  input  logic                     line_start_i,
  input  logic                     frame_end_i,
  output logic                     detected_o,
  output logic                     detected_d_o
);

  localparam int unsigned ON_W  = $clog2(deblur_on_frames + 1);
  localparam int unsigned OFF_W = $clog2(deblur_off_frames + 1);

  logic [color_width_i-1:0] r_cur_q, r_cur_d, g_cur_q, g_cur_d;
  logic [color_width_i-1:0] r_prev_q, r_prev_d, g_prev_q, g_prev_d, b_prev_q, b_prev_d;
  logic                     parity_q, parity_d;
  logic                     frame_dirty_q, frame_dirty_d;
  logic [ON_W-1:0]          clean_cnt_q, clean_cnt_d;
  logic [OFF_W-1:0]         dirty_cnt_q, dirty_cnt_d;
  logic                     detected_q, detected_d;
  logic                     pix_done, pixel_eq, violation;

  always_comb begin
    r_cur_d       = r_cur_q;
    g_cur_d       = g_cur_q;
    r_prev_d      = r_prev_q;
    g_prev_d      = g_prev_q;
    b_prev_d      = b_prev_q;
    parity_d      = parity_q;
    frame_dirty_d = frame_dirty_q;
    clean_cnt_d   = clean_cnt_q;
    dirty_cnt_d   = dirty_cnt_q;
    detected_d    = detected_q;

    pix_done  = data_cyc_i && (data_cnt_i == SLOT_B);
    pixel_eq  = (r_cur_q == r_prev_q) && (g_cur_q == g_prev_q) && (vd_i == b_prev_q);
    violation = pix_done && active_i && parity_q && !pixel_eq;

    if (data_cyc_i && (data_cnt_i == SLOT_R)) r_cur_d = vd_i;
    if (data_cyc_i && (data_cnt_i == SLOT_G)) g_cur_d = vd_i;
    if (pix_done) begin
      r_prev_d = r_cur_q;
      g_prev_d = g_cur_q;
      b_prev_d = vd_i;
      parity_d = ~parity_q;
    end
    if (line_start_i) parity_d = 1'b0;
    if (violation)    frame_dirty_d = 1'b1;

    // A violation on the closing cycle still belongs to the closing frame.
    if (frame_end_i) begin
      if (frame_dirty_q || violation) begin
        clean_cnt_d = '0;
        if (dirty_cnt_q != OFF_W'(deblur_off_frames)) dirty_cnt_d = dirty_cnt_q + 1'b1;
      end else begin
        dirty_cnt_d = '0;
        if (clean_cnt_q != ON_W'(deblur_on_frames)) clean_cnt_d = clean_cnt_q + 1'b1;
      end
      if (clean_cnt_d == ON_W'(deblur_on_frames))   detected_d = 1'b1;
      if (dirty_cnt_d == OFF_W'(deblur_off_frames)) detected_d = 1'b0;
      frame_dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_cur_q       <= '0;
      g_cur_q       <= '0;
      r_prev_q      <= '0;
      g_prev_q      <= '0;
      b_prev_q      <= '0;
      parity_q      <= 1'b0;
      frame_dirty_q <= 1'b0;
      clean_cnt_q   <= '0;
      dirty_cnt_q   <= '0;
      detected_q    <= 1'b0;
    end else begin
      r_cur_q       <= r_cur_d;
      g_cur_q       <= g_cur_d;
      r_prev_q      <= r_prev_d;
      g_prev_q      <= g_prev_d;
      b_prev_q      <= b_prev_d;
      parity_q      <= parity_d;
      frame_dirty_q <= frame_dirty_d;
      clean_cnt_q   <= clean_cnt_d;
      dirty_cnt_q   <= dirty_cnt_d;
      detected_q    <= detected_d;
    end
  end

  assign detected_o   = detected_q;
  assign detected_d_o = detected_d;

endmodule

// File: rtl/n64a_vinfo_ctrl.sv
// Video demux controller on VCLK.
//   In:  VCLK, nRST (sync, active-low), nVDSYNC, VD_i, deblur_cfg_i, n15bit_mode_i.
//   Out: demuxparams_o = {data_cnt, vmode, ndo_deblur, n15bit_mode},
//        interlaced_o, deblur_detected_o.
module n64a_vinfo_ctrl
  import n64a_vinfo_ctrl_pkg::*;
#(
  parameter int unsigned color_width_i     = COLOR_WIDTH_I,
  parameter int unsigned pal_line_thresh   = PAL_LINE_THRESH,
  parameter int unsigned deblur_on_frames  = DEBLUR_ON_FRAMES,
  parameter int unsigned deblur_off_frames = DEBLUR_OFF_FRAMES
) (
  input  logic                     VCLK,
  input  logic                     nRST,
  input  logic                     nVDSYNC,
  input  logic [color_width_i-1:0] VD_i,
  input  logic [1:0]               deblur_cfg_i,
  input  logic                     n15bit_mode_i,
  output logic [4:0]               demuxparams_o,
  output logic                     interlaced_o,
  output logic                     deblur_detected_o
);

  // sync_prev keeps only {nVSYNC, nHSYNC}; clamp/csync feed nothing here.
  logic [1:0]            sync_prev_q, sync_prev_d;
  logic [1:0]            sync_cur;
  slot_e                 data_cnt_q, data_cnt_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d, field_lines_q, field_lines_d;
  logic                  vmode_q, vmode_d, interlaced_q, interlaced_d;
  logic                  ndo_deblur_q, ndo_deblur_d, n15bit_q, n15bit_d;
  logic                  sync_cyc, nvsync_fall, nhsync_fall, nhsync_rise;
  logic                  det_q, det_d;

  always_comb begin
    sync_cyc    = ~nVDSYNC;
    sync_cur    = {VD_i[NVSYNC_BIT], VD_i[NHSYNC_BIT]};
    nvsync_fall = sync_cyc &  sync_prev_q[1] & ~sync_cur[1];
    nhsync_fall = sync_cyc &  sync_prev_q[0] & ~sync_cur[0];
    nhsync_rise = sync_cyc & ~sync_prev_q[0] &  sync_cur[0];

    sync_prev_d   = sync_cyc ? sync_cur : sync_prev_q;
    data_cnt_d    = next_slot(sync_cyc, data_cnt_q);
    n15bit_d      = sync_cyc ? n15bit_mode_i : n15bit_q;
    line_cnt_d    = line_cnt_q;
    field_lines_d = field_lines_q;
    vmode_d       = vmode_q;
    interlaced_d  = interlaced_q;
    ndo_deblur_d  = ndo_deblur_q;

    if (nhsync_fall && (line_cnt_q != '1)) line_cnt_d = line_cnt_q + 1'b1;

    // Capture before restart; the previous field length is field_lines_q here.
    if (nvsync_fall) begin
      field_lines_d = line_cnt_q;
      line_cnt_d    = nhsync_fall ? LINE_CNT_W'(1) : '0;
      vmode_d       = (32'(line_cnt_q) >= pal_line_thresh);
      interlaced_d  = line_cnt_q[0] ^ field_lines_q[0];
      case (deblur_cfg_i)
        DEBLUR_AUTO:     ndo_deblur_d = interlaced_d | ~det_d;
        DEBLUR_FORCE_ON: ndo_deblur_d = interlaced_d;
        default:         ndo_deblur_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      sync_prev_q   <= '1;
      data_cnt_q    <= SLOT_IDLE;
      line_cnt_q    <= '0;
      field_lines_q <= '0;
      vmode_q       <= 1'b0;
      interlaced_q  <= 1'b0;
      ndo_deblur_q  <= 1'b1;
      n15bit_q      <= 1'b1;
    end else begin
      sync_prev_q   <= sync_prev_d;
      data_cnt_q    <= data_cnt_d;
      line_cnt_q    <= line_cnt_d;
      field_lines_q <= field_lines_d;
      vmode_q       <= vmode_d;
      interlaced_q  <= interlaced_d;
      ndo_deblur_q  <= ndo_deblur_d;
      n15bit_q      <= n15bit_d;
    end
  end

  n64a_deblur_detect #(
    .color_width_i    (color_width_i),
    .deblur_on_frames (deblur_on_frames),
    .deblur_off_frames(deblur_off_frames)
  ) u_deblur_detect (
    .clk         (VCLK),
    .nrst        (nRST),
    .data_cyc_i  (nVDSYNC),
    .data_cnt_i  (data_cnt_q),
    .vd_i        (VD_i),
    .active_i    (sync_prev_q[1] & sync_prev_q[0]),
    .line_start_i(nhsync_rise),
    .frame_end_i (nvsync_fall),
    .detected_o  (det_q),
    .detected_d_o(det_d)
  );

  assign demuxparams_o     = {data_cnt_q, vmode_q, ndo_deblur_q, n15bit_q};
  assign interlaced_o      = interlaced_q;
  assign deblur_detected_o = det_q;

endmodule

// File: tb/tb_n64a_vinfo_ctrl.sv
module tb_n64a_vinfo_ctrl;

  localparam int PAL = 288;
  localparam int ON  = 4;
  localparam int OFF = 2;

  logic       VCLK = 1'b0;
  logic       nRST, nVDSYNC, n15bit_mode_i;
  logic [6:0] VD_i;
  logic [1:0] deblur_cfg_i;
  logic [4:0] demuxparams_o;
  logic       interlaced_o, deblur_detected_o;

  int ncmp  = 0;
  int nfail = 0;

  // Field-level reference state
  int m_lines, m_prevn, m_clean, m_dirty;
  bit m_vmode, m_inter, m_det, m_ndo, m_n15, m_fdirty;

  always #5 VCLK = ~VCLK;

  n64a_vinfo_ctrl #(
    .color_width_i    (7),
    .pal_line_thresh  (PAL),
    .deblur_on_frames (ON),
    .deblur_off_frames(OFF)
  ) dut (
    .VCLK             (VCLK),
    .nRST             (nRST),
    .nVDSYNC          (nVDSYNC),
    .VD_i             (VD_i),
    .deblur_cfg_i     (deblur_cfg_i),
    .n15bit_mode_i    (n15bit_mode_i),
    .demuxparams_o    (demuxparams_o),
    .interlaced_o     (interlaced_o),
    .deblur_detected_o(deblur_detected_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_vmode"}, 32'(demuxparams_o[2]), 32'(m_vmode));
    chk({tag, "_ndo"},   32'(demuxparams_o[1]), 32'(m_ndo));
    chk({tag, "_n15"},   32'(demuxparams_o[0]), 32'(m_n15));
    chk({tag, "_intl"},  32'(interlaced_o),     32'(m_inter));
    chk({tag, "_det"},   32'(deblur_detected_o), 32'(m_det));
  endtask

  task automatic model_reset();
    m_lines = 0; m_prevn = 0; m_clean = 0; m_dirty = 0;
    m_vmode = 0; m_inter = 0; m_det = 0; m_ndo = 1; m_n15 = 1; m_fdirty = 0;
  endtask

  task automatic cyc(input logic nvd, input logic [6:0] vd);
    nVDSYNC = nvd;
    VD_i    = vd;
    @(posedge VCLK);
    #1;
  endtask

  task automatic sync_sample(input logic [3:0] nib);
    if (nRST) m_n15 = n15bit_mode_i;
    cyc(1'b0, {3'($urandom), nib});
  endtask

  task automatic pixel(input logic [20:0] rgb, input bit extra);
    sync_sample(4'hF);
    chk("dcnt_r", 32'(demuxparams_o[4:3]), 32'd1);
    n15bit_mode_i = 1'($urandom);
    cyc(1'b1, rgb[20:14]);
    chk("dcnt_g", 32'(demuxparams_o[4:3]), 32'd2);
    chk("n15_hold", 32'(demuxparams_o[0]), 32'(m_n15));
    cyc(1'b1, rgb[13:7]);
    chk("dcnt_b", 32'(demuxparams_o[4:3]), 32'd3);
    cyc(1'b1, rgb[6:0]);
    chk("dcnt_end", 32'(demuxparams_o[4:3]), 32'd0);
    if (extra) begin
      cyc(1'b1, 7'($urandom));
      chk("dcnt_extra", 32'(demuxparams_o[4:3]), 32'd0);
    end
  endtask

  task automatic boundary_model();
    int n;
    n       = m_lines;
    m_lines = 1;
    m_vmode = (n >= PAL);
    m_inter = ((n % 2) != (m_prevn % 2));
    m_prevn = n;
    if (m_fdirty) begin
      m_dirty++; m_clean = 0;
      if (m_dirty >= OFF) m_det = 0;
    end else begin
      m_clean++; m_dirty = 0;
      if (m_clean >= ON) m_det = 1;
    end
    m_fdirty = 0;
    if (deblur_cfg_i[1])      m_ndo = 1;
    else if (deblur_cfg_i[0]) m_ndo = m_inter;
    else                      m_ndo = m_inter | !m_det;
  endtask

  task automatic emit_line(input bit vstart, input int npix, input bit mismatch, input bit extra);
    logic [20:0] prev, cur;
    prev = '0;
    if (vstart) begin
      chk_state("stable");
      boundary_model();
    end else if (m_lines < 511) begin
      m_lines++;
    end
    sync_sample({~vstart, 1'b1, 1'b0, 1'b1});
    if (vstart) chk_state("field");
    sync_sample(4'hF);
    for (int i = 0; i < npix; i++) begin
      if (i % 2 == 0) begin
        cur = 21'($urandom);
      end else begin
        cur = prev;
        if (mismatch && i == 1)
          cur = cur ^ (21'($urandom_range(1, 127)) << (7 * $urandom_range(0, 2)));
        if (cur != prev) m_fdirty = 1;
      end
      pixel(cur, extra);
      prev = cur;
    end
  endtask

  task automatic emit_field(input int n, input bit mismatch);
    for (int l = 0; l < n; l++)
      emit_line(l == 0, (l == 2 || l == 3) ? 4 : 0, mismatch && (l == 2), 1'b0);
  endtask

  initial begin
    nRST = 1'b0; nVDSYNC = 1'b1; VD_i = '0; deblur_cfg_i = 2'b00; n15bit_mode_i = 1'b1;
    cyc(1'b1, 7'h00);
    cyc(1'b1, 7'h00);
    model_reset();
    chk("rst_dp",   32'(demuxparams_o),     32'h03);
    chk("rst_intl", 32'(interlaced_o),      32'd0);
    chk("rst_det",  32'(deblur_detected_o), 32'd0);
    nRST = 1'b1;

    // Slot sequence including a surplus data cycle after B
    emit_line(1'b0, 4, 1'b0, 1'b1);

    // Interlaced NTSC, never force-on
    for (int f = 0; f < 4; f++) begin
      case ($urandom_range(0, 2))
        0:       deblur_cfg_i = 2'b00;
        1:       deblur_cfg_i = 2'b10;
        default: deblur_cfg_i = 2'b11;
      endcase
      emit_field((f % 2 == 0) ? 263 : 262, 1'($urandom));
    end

    // Progressive PAL, dirty content
    for (int f = 0; f < 3; f++) begin
      deblur_cfg_i = 2'($urandom);
      emit_field(312, 1'b1);
    end

    // Auto-detect: clean progressive, then violations, then clean again
    deblur_cfg_i = 2'b00;
    for (int f = 0; f < 5; f++) emit_field(263, 1'b0);
    for (int f = 0; f < 2; f++) emit_field(263, 1'b1);
    for (int f = 0; f < 4; f++) emit_field(263, 1'b0);

    // Force off mid-field while detected; takes effect at the boundary
    for (int l = 0; l < 263; l++) begin
      if (l == 131) begin
        deblur_cfg_i = 2'b10;
        chk_state("cfg_mid");
      end
      emit_line(l == 0, (l == 2 || l == 3) ? 4 : 0, 1'b0, 1'b0);
    end
    emit_field(263, 1'b0);

    // Reset in the middle of a pixel, then detection restarts from zero
    deblur_cfg_i = 2'b00;
    sync_sample(4'hF);
    cyc(1'b1, 7'($urandom));
    nRST = 1'b0;
    cyc(1'b1, 7'($urandom));
    model_reset();
    chk("mrst_dp",   32'(demuxparams_o),     32'h03);
    chk("mrst_intl", 32'(interlaced_o),      32'd0);
    chk("mrst_det",  32'(deblur_detected_o), 32'd0);
    nRST = 1'b1;
    for (int f = 0; f < 4; f++) emit_field(263, 1'b0);
    emit_line(1'b1, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
